// File: rtl/reg_two_write_merge.sv
// reg_two_write_merge: merges two write streams, A passed through, B queued and issued when A is idle or starving B
module reg_two_write_merge #(
    parameter int width   = 1,
    parameter int depth   = 4,
    parameter int cntw    = 3,
    parameter int maxwait = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             A_EN,
    input  logic [width-1:0] A_DATA,
    output logic             A_RDY,
    input  logic             B_EN,
    input  logic [width-1:0] B_DATA,
    output logic             B_RDY,
    output logic             ENA,
    output logic [width-1:0] D_INA,
    output logic             ENB,
    output logic [width-1:0] D_INB,
    output logic [cntw-1:0]  B_COUNT
);
    localparam int PW = $clog2(depth);
    localparam int WW = $clog2(maxwait + 1) + 1;
    typedef enum logic {NORMAL, FORCE} state_t;
    state_t           state_q, state_d;
    logic [WW-1:0]    wait_q, wait_d;
    logic [width-1:0] mem_q [depth];
    logic [PW-1:0]    rd_q, wr_q;
    logic [cntw-1:0]  count_q;
    logic             ena_q, enb_q;
    logic [width-1:0] dina_q, dinb_q;
    logic             force_w, nonempty, a_fire, b_push, issue_b, wait_hit;
    assign nonempty = count_q != '0;
    assign a_fire   = A_EN && A_RDY;
    assign b_push   = B_EN && B_RDY;
    assign issue_b  = nonempty && (force_w || !A_EN);
    assign wait_hit = (maxwait > 0) && nonempty && a_fire && (wait_q == WW'(maxwait - 1));
    // starvation state and wait counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= NORMAL;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end
    // FORCE is entered when B has been blocked maxwait times and always lasts one cycle
    always_comb begin
        state_d = (state_q == NORMAL && wait_hit) ? FORCE : NORMAL;
        wait_d  = (nonempty && a_fire && !wait_hit) ? wait_q + WW'(1) : '0;
    end
    // handshake flags derived from the registered state
    always_comb begin
        force_w = state_q == FORCE;
        A_RDY   = !force_w;
        B_RDY   = count_q != cntw'(depth);
    end
    // FIFO bookkeeping and registered downstream outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            ena_q   <= 1'b0;
            enb_q   <= 1'b0;
            dina_q  <= '0;
            dinb_q  <= '0;
        end else begin
            rd_q    <= rd_q + PW'(issue_b);
            wr_q    <= wr_q + PW'(b_push);
            count_q <= count_q + cntw'(b_push) - cntw'(issue_b);
            ena_q   <= a_fire;
            enb_q   <= issue_b;
            if (a_fire) dina_q <= A_DATA;
            if (issue_b) dinb_q <= mem_q[rd_q];
        end
    end
    // FIFO storage needs no reset; the count gates every read
    always_ff @(posedge CLK) begin
        if (b_push) mem_q[wr_q] <= B_DATA;
    end
    assign ENA     = ena_q;
    assign ENB     = enb_q;
    assign D_INA   = dina_q;
    assign D_INB   = dinb_q;
    assign B_COUNT = count_q;
endmodule

// File: tb/tb_reg_two_write_merge.sv
// tb_reg_two_write_merge: directed and random stimulus against a queue-based model
module tb_reg_two_write_merge;
    logic       CLK = 1'b0;
    logic       RST, A_EN, B_EN, A_RDY, B_RDY, ENA, ENB;
    logic [7:0] A_DATA, B_DATA, D_INA, D_INB;
    logic [2:0] B_COUNT;
    int         checks = 0, failures = 0;
    logic [7:0] bq [$];
    bit         m_force, m_ena, m_enb;
    int         m_wait;
    logic [7:0] m_dina, m_dinb;

    reg_two_write_merge #(.width(8), .depth(4), .cntw(3), .maxwait(3)) dut (
        .CLK(CLK), .RST(RST), .A_EN(A_EN), .A_DATA(A_DATA), .A_RDY(A_RDY),
        .B_EN(B_EN), .B_DATA(B_DATA), .B_RDY(B_RDY), .ENA(ENA), .D_INA(D_INA),
        .ENB(ENB), .D_INB(D_INB), .B_COUNT(B_COUNT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        bq.delete();
        m_force = 0; m_wait = 0; m_ena = 0; m_enb = 0; m_dina = 0; m_dinb = 0;
    endtask

    task automatic step(input bit r, input bit a, input logic [7:0] ad, input bit b, input logic [7:0] bd);
        bit a_fire, b_push, issue, nonempty;
        @(negedge CLK);
        chk("ena", 32'(ENA), 32'(m_ena));
        chk("dina", 32'(D_INA), 32'(m_dina));
        chk("enb", 32'(ENB), 32'(m_enb));
        chk("dinb", 32'(D_INB), 32'(m_dinb));
        chk("count", 32'(B_COUNT), 32'(bq.size()));
        chk("a_rdy", 32'(A_RDY), 32'(!m_force));
        chk("b_rdy", 32'(B_RDY), 32'(bq.size() != 4));
        chk("excl", 32'(ENA && ENB), 32'(0));
        RST = r; A_EN = a; A_DATA = ad; B_EN = b; B_DATA = bd;
        if (r) begin
            model_reset();
            return;
        end
        nonempty = bq.size() > 0;
        a_fire = a && !m_force;
        b_push = b && bq.size() < 4;
        issue = nonempty && (m_force || !a);
        m_ena = a_fire;
        if (a_fire) m_dina = ad;
        m_enb = issue;
        if (issue) m_dinb = bq.pop_front();
        if (b_push) bq.push_back(bd);
        if (m_force) begin
            m_force = 0; m_wait = 0;
        end else if (nonempty && a_fire) begin
            m_wait++;
            if (m_wait == 3) begin
                m_force = 1; m_wait = 0;
            end
        end else m_wait = 0;
    endtask

    initial begin
        int pa, pb;
        RST = 1; A_EN = 1; B_EN = 1; A_DATA = 8'hFF; B_DATA = 8'hEE;
        repeat (2) @(posedge CLK);
        model_reset();
        step(0, 0, 0, 0, 0);
        step(0, 1, 8'h5A, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 8'h11);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 1, 8'h22, 1, 8'h33);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) step(0, 1, 8'(i + 8'h80), 1, 8'(i));
        step(0, 1, 8'h90, 1, 8'h05);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 8'h77);
        for (int i = 0; i < 7; i++) step(0, 1, 8'(8'hA0 + i), 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 8'hC0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1, 8'(i));
        step(1, 0, 0, 1, 8'hDD);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            pa = $urandom_range(0, 100);
            pb = $urandom_range(0, 100);
            for (int i = 0; i < 250; i++)
                step($urandom_range(0, 99) == 0, $urandom_range(0, 99) < pa, 8'($urandom),
                     $urandom_range(0, 99) < pb, 8'($urandom));
        end
        step(0, 0, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
